axis_pack_fifo: RTL and testbench

AXIS_PACK_FIFO -- requirements
Module: axis_pack_fifo

---
 rtl/fifo_mig_pkg.sv | 44 ++++
 rtl/sync_fifo.sv | 75 +++++++
 rtl/axis_pack_fifo.sv | 103 ++++++++++
 tb/tb_axis_pack_fifo.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_mig_pkg.sv
// fifo_mig_pkg
// Shared definitions for the AXIS-to-memory-controller datapath: default beat
// and word widths, the pack-ratio legality check and a ceil(log2) helper.
// Used by axis_pack_fifo, its sync_fifo storage and the memory controller.
package fifo_mig_pkg;

  // Default user beat width and packed word width. The packed width is
  // MIG_Data_Port_Size * PHY_to_UI_Rate of the memory controller.
  localparam int S_DATA_WIDTH_DEF = 32;
  localparam int M_DATA_WIDTH_DEF = 128;

  // Largest number of beats packed into one word.
  localparam int MAX_RATIO = 16;

  // Storage depth limits.
  localparam int MIN_DEPTH = 2;
  localparam int MAX_DEPTH = 1024;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  // A word must hold a power-of-two number of beats, 1..MAX_RATIO.
  function automatic bit ratio_ok(input int s_width, input int m_width);
    if (s_width <= 0 || m_width <= 0) return 1'b0;
    if ((m_width % s_width) != 0) return 1'b0;
    return is_pow2(m_width / s_width) && ((m_width / s_width) <= MAX_RATIO);
  endfunction

  function automatic bit depth_ok(input int depth);
    return is_pow2(depth) && (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// First-word-fall-through synchronous FIFO: storage array, read/write
// pointers with one wrap bit, stored-word count and output valid.
//
// Ports:
//   aclk, aresetn   clock, synchronous active-low reset
//   wr_en, wr_data  push request and word (ignored while full)
//   full            storage holds DEPTH words
//   rd_en           consumer ready; a pop happens on rd_en && rd_valid
//   rd_data         oldest stored word (zero while empty or in reset)
//   rd_valid        storage not empty
//   count           stored-word count, zero-extended to 32 bits
module sync_fifo
  import fifo_mig_pkg::*;
#(
  parameter int WIDTH = M_DATA_WIDTH_DEF,
  parameter int DEPTH = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [31:0]      count
);

  localparam int AW = clog2(DEPTH);

  generate
    if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be a power of two in 2..1024");
    end
  endgenerate

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      used;
  logic             do_wr;
  logic             do_rd;

  // The extra pointer bit separates full (MSB set) from empty (zero):
  // used never exceeds DEPTH = 2**AW.
  assign used     = wr_ptr - rd_ptr;
  assign full     = used[AW];
  assign rd_valid = aresetn && (used != '0);
  assign do_wr    = aresetn && wr_en && !full;
  assign do_rd    = rd_en && rd_valid;
  assign count    = aresetn ? 32'(used) : 32'd0;
  assign rd_data  = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: the storage array has no reset; an entry is only observable after
  // it has been written, and a reset-free array maps onto RAM primitives.
  always_ff @(posedge aclk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/axis_pack_fifo.sv
// axis_pack_fifo
// Packs S_DATA_WIDTH AXI-Stream beats into M_DATA_WIDTH words for the memory
// controller and buffers them in a first-word-fall-through FIFO. The first
// beat of a word lands in the most-significant lane (upper-half-first write
// order). A word completes on its last lane or on s_tlast; unfilled lanes
// are zero.
//
// Ports:
//   aclk, aresetn              clock, synchronous active-low reset
//   s_tdata/s_tvalid/s_tready  input beat handshake
//   s_tlast                    end of packet, closes the current word
//   m_tdata/m_tvalid/m_tready  packed word handshake
//   m_count                    stored-word count (controller in_wr_count)
module axis_pack_fifo
  import fifo_mig_pkg::*;
#(
  parameter int S_DATA_WIDTH = S_DATA_WIDTH_DEF,
  parameter int M_DATA_WIDTH = M_DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH   = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [S_DATA_WIDTH-1:0] s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  output logic [M_DATA_WIDTH-1:0] m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [31:0]             m_count
);

  localparam int RATIO  = M_DATA_WIDTH / S_DATA_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? clog2(RATIO) : 1;

  generate
    if (!ratio_ok(S_DATA_WIDTH, M_DATA_WIDTH)) begin : g_bad_ratio
      $error("axis_pack_fifo: M_DATA_WIDTH/S_DATA_WIDTH must be a power of two in 1..16");
    end
  endgenerate

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
  localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);

  logic [LANE_W-1:0]       lane;
  logic [M_DATA_WIDTH-1:0] assembly;
  logic [M_DATA_WIDTH-1:0] word_next;
  int                      lane_shift;
  logic                    beat;
  logic                    complete;
  logic                    push;
  logic                    fifo_full;

  // Full storage stalls every beat, even ones that would not complete a word,
  // so a completing beat can always be pushed in the cycle it transfers.
  assign s_tready = aresetn && !fifo_full;
  assign beat     = s_tvalid && s_tready;
  assign complete = (lane == LAST_LANE) || s_tlast;
  assign push     = beat && complete;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    lane_shift = 0;
    word_next  = assembly;
    // Lane k sits at bit offset (RATIO-1-k)*S: first beat in the top lane.
    lane_shift = (RATIO - 1 - int'(lane)) * S_DATA_WIDTH;
    word_next  = assembly | (M_DATA_WIDTH'(s_tdata) << lane_shift);
  end

  // The assembly register clears on completion so the next word starts with
  // all lanes zero; a short (s_tlast) word therefore has zero-filled tails.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      lane     <= '0;
      assembly <= '0;
    end else if (beat) begin
      if (complete) begin
        lane     <= '0;
        assembly <= '0;
      end else begin
        lane     <= lane + LANE_ONE;
        assembly <= word_next;
      end
    end
  end

  sync_fifo #(
    .WIDTH (M_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .wr_en    (push),
    .wr_data  (word_next),
    .full     (fifo_full),
    .rd_en    (m_tready),
    .rd_data  (m_tdata),
    .rd_valid (m_tvalid),
    .count    (m_count)
  );

endmodule

// File: tb/tb_axis_pack_fifo.sv
// Self-checking bench for axis_pack_fifo (S=32, M=128, DEPTH=32).
module tb_axis_pack_fifo;

  localparam int S = 32;
  localparam int M = 128;
  localparam int D = 32;
  localparam int R = M / S;
  localparam int N_RAND_WORDS = 1000;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [S-1:0] s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic         s_tlast = 1'b0;
  logic [M-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic [31:0]  m_count;

  axis_pack_fifo #(
    .S_DATA_WIDTH (S),
    .M_DATA_WIDTH (M),
    .FIFO_DEPTH   (D)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_count  (m_count)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference packing: concatenate the beats of a word in arrival order,
  // first beat leftmost, and pad the missing lanes with zeros.
  function automatic logic [M-1:0] pack_word(input logic [S-1:0] b [R], input int n);
    logic [M-1:0] w;
    w = '0;
    for (int i = 0; i < R; i++) w = {w[M-S-1:0], (i < n) ? b[i] : {S{1'b0}}};
    return w;
  endfunction

  function automatic logic [M-1:0] pack1(input logic [S-1:0] d);
    logic [S-1:0] b [R];
    for (int i = 0; i < R; i++) b[i] = '0;
    b[0] = d;
    return pack_word(b, 1);
  endfunction

  // Drive one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [S-1:0] d, input logic l);
    int n;
    n = 0;
    @(negedge aclk);
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    while (!s_tready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (!s_tready) check("send_beat timeout", M'(s_tready), M'(1'b1));
    else @(posedge aclk);
    #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  // Expect a valid head word, compare it, and pop it.
  task automatic pop_check(input string name, input logic [M-1:0] exp);
    @(negedge aclk);
    check({name, " valid"}, M'(m_tvalid), M'(1'b1));
    check(name, m_tdata, exp);
    m_tready = 1'b1;
    @(posedge aclk);
    #1 m_tready = 1'b0;
  endtask

  logic [M-1:0] q [$];

  task automatic drain(input string name);
    while (q.size() != 0) pop_check(name, q.pop_front());
    @(negedge aclk);
    check({name, " empty count"}, M'(m_count), M'(0));
  endtask

  typedef struct {
    logic [S-1:0] d;
    logic         last;
    int           exp_count;
    logic         do_pop;
    logic [M-1:0] exp_word;
  } vec_t;

  vec_t vecs [$];

  // Random phase state.
  logic [M-1:0] rq [$];
  int           got;
  int           deadline;

  initial begin
    // Packing vectors, applied with m_tready low; completed words popped.
    vecs.push_back('{32'h11111111, 1'b0, 0, 1'b0, '0});
    vecs.push_back('{32'h22222222, 1'b0, 0, 1'b0, '0});
    vecs.push_back('{32'h33333333, 1'b0, 0, 1'b0, '0});
    vecs.push_back('{32'h44444444, 1'b0, 1, 1'b1,
                     128'h11111111_22222222_33333333_44444444});
    vecs.push_back('{32'h0000000A, 1'b0, 0, 1'b0, '0});
    vecs.push_back('{32'h0000000B, 1'b1, 1, 1'b1,
                     128'h0000000A_0000000B_00000000_00000000});
    vecs.push_back('{32'h0000000C, 1'b1, 1, 1'b1,
                     128'h0000000C_00000000_00000000_00000000});
    vecs.push_back('{32'h00000005, 1'b0, 0, 1'b0, '0});
    vecs.push_back('{32'h00000006, 1'b0, 0, 1'b0, '0});
    vecs.push_back('{32'h00000007, 1'b1, 1, 1'b1,
                     128'h00000005_00000006_00000007_00000000});
    vecs.push_back('{32'hA5A5A5A5, 1'b0, 0, 1'b0, '0});
    vecs.push_back('{32'h5A5A5A5A, 1'b0, 0, 1'b0, '0});
    vecs.push_back('{32'hDEADBEEF, 1'b0, 0, 1'b0, '0});
    vecs.push_back('{32'hCAFEF00D, 1'b1, 1, 1'b1,
                     128'hA5A5A5A5_5A5A5A5A_DEADBEEF_CAFEF00D});

    // Reset state.
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    check("rst s_tready", M'(s_tready), M'(0));
    check("rst m_tvalid", M'(m_tvalid), M'(0));
    check("rst m_count",  M'(m_count),  M'(0));
    check("rst m_tdata",  m_tdata,      M'(0));
    aresetn = 1'b1;
    #1 check("s_tready after reset", M'(s_tready), M'(1));

    // Table-driven packing.
    foreach (vecs[i]) begin
      send_beat(vecs[i].d, vecs[i].last);
      check($sformatf("vec%0d count", i), M'(m_count), M'(vecs[i].exp_count));
      if (vecs[i].do_pop) begin
        pop_check($sformatf("vec%0d word", i), vecs[i].exp_word);
        check($sformatf("vec%0d count after pop", i), M'(m_count), M'(0));
      end
    end

    // Fill to full, hold a beat, release one slot.
    for (int w = 0; w < D; w++) begin
      logic [S-1:0] b [R];
      for (int k = 0; k < R; k++) begin
        b[k] = 32'(w * 16 + k + 1);
        send_beat(b[k], 1'b0);
      end
      q.push_back(pack_word(b, R));
    end
    @(negedge aclk);
    check("full m_count", M'(m_count), M'(D));
    check("full s_tready", M'(s_tready), M'(0));
    s_tdata = 32'hDEAD0001; s_tlast = 1'b1; s_tvalid = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check("held s_tready", M'(s_tready), M'(0));
      check("held m_count", M'(m_count), M'(D));
    end
    check("full head word", m_tdata, q.pop_front());
    m_tready = 1'b1;
    @(posedge aclk);
    #1 m_tready = 1'b0;
    check("s_tready after pop", M'(s_tready), M'(1));
    @(posedge aclk);
    #1 s_tvalid = 1'b0; s_tlast = 1'b0;
    q.push_back(pack1(32'hDEAD0001));
    @(negedge aclk);
    check("refill m_count", M'(m_count), M'(D));
    drain("full drain");

    // Simultaneous push and pop at count 5.
    for (int i = 0; i < 5; i++) begin
      send_beat(32'h500 + 32'(i), 1'b1);
      q.push_back(pack1(32'h500 + 32'(i)));
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      check("pp count", M'(m_count), M'(5));
      check("pp word", m_tdata, q.pop_front());
      s_tdata = 32'h600 + 32'(c); s_tlast = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
      q.push_back(pack1(32'h600 + 32'(c)));
      @(posedge aclk);
      #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    @(negedge aclk);
    check("pp final count", M'(m_count), M'(5));
    drain("pp drain");

    // Reset mid-word with stored words.
    for (int i = 0; i < 3; i++) send_beat(32'h700 + 32'(i), 1'b1);
    send_beat(32'h77, 1'b0);
    send_beat(32'h88, 1'b0);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("midrst s_tready", M'(s_tready), M'(0));
    check("midrst m_tvalid", M'(m_tvalid), M'(0));
    check("midrst m_count",  M'(m_count),  M'(0));
    check("midrst m_tdata",  m_tdata,      M'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("postrst m_count",  M'(m_count),  M'(0));
    check("postrst m_tvalid", M'(m_tvalid), M'(0));
    for (int k = 0; k < R; k++) send_beat(32'h91 + 32'(k), 1'b0);
    check("postrst word count", M'(m_count), M'(1));
    pop_check("postrst word", 128'h00000091_00000092_00000093_00000094);

    // Random stream against the reference model.
    got = 0;
    deadline = cyc + 40000;
    fork
      begin : driver
        for (int w = 0; w < N_RAND_WORDS && cyc < deadline; w++) begin
          logic [S-1:0] b [R];
          logic         lst [R];
          int nb;
          nb = $urandom_range(1, R);
          for (int k = 0; k < R; k++) begin
            b[k] = $urandom;
            lst[k] = 1'b0;
          end
          lst[nb-1] = (nb < R) ? 1'b1 : 1'($urandom_range(0, 1));
          rq.push_back(pack_word(b, nb));
          for (int k = 0; k < nb; k++) begin
            logic sent;
            sent = 1'b0;
            while (!sent && cyc < deadline) begin
              @(negedge aclk);
              s_tvalid = 1'($urandom_range(0, 1));
              s_tdata = b[k];
              s_tlast = lst[k];
              if (s_tvalid && s_tready) sent = 1'b1;
            end
          end
        end
        @(negedge aclk);
        s_tvalid = 1'b0; s_tlast = 1'b0;
      end
      begin : monitor
        while (got < N_RAND_WORDS && cyc < deadline) begin
          @(negedge aclk);
          check("rand count bound", M'(m_count <= 32'(D)), M'(1));
          m_tready = 1'($urandom_range(0, 1));
          if (m_tvalid && m_tready) begin
            if (rq.size() == 0) check("rand unexpected word", m_tdata, M'(0) - M'(1));
            else check($sformatf("rand word %0d", got), m_tdata, rq.pop_front());
            got++;
          end
        end
        @(negedge aclk);
        m_tready = 1'b0;
      end
    join
    check("rand words received", M'(got), M'(N_RAND_WORDS));
    check("rand model empty", M'(rq.size()), M'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
